rsa_uart_sequencer: RTL and testbench

//  Frame controller between UART RX/TX and the RSA core. Detects a sync byte, then steers the

---
 rtl/rsa_uart_sequencer_pkg.sv | 29 ++
 rtl/rsa_uart_sequencer_p2s.sv | 75 +++++++
 rtl/rsa_uart_sequencer.sv | 145 ++++++++++++++
 tb/tb_rsa_uart_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_uart_sequencer_pkg.sv
// Shared types for the RSA UART frame sequencer: top FSM states, byte-streamer states, helpers.
// No logic of its own; imported by the sequencer and its parallel-to-serial sub-block.
// Holds the sync-byte default used when the parent does not override it.
package rsa_uart_sequencer_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_M = 3'd1,
      ST_LOAD_E = 3'd2,
      ST_LOAD_K = 3'd3,
      ST_START  = 3'd4,
      ST_WAIT   = 3'd5,
      ST_SEND   = 3'd6
   } seq_state_t;

   typedef enum logic [1:0] {
      PS_IDLE      = 2'd0,
      PS_SEND      = 2'd1,
      PS_SEND_WAIT = 2'd2
   } p2s_state_t;

   // Index width for a count of 'value' items, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/rsa_uart_sequencer_p2s.sv
// Streams an N-bit result to UART TX one byte per request, most significant byte first.
// Latency: first tx_start two cycles after load; done is combinational on the final byte's release.
// Backpressure: holds each next byte until tx_busy drops (tx_busy ignored the cycle after tx_start).
module rsa_uart_sequencer_p2s
   import rsa_uart_sequencer_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] result_in,
   input  logic         tx_busy,
   output logic         tx_start,
   output logic [7:0]   tx_byte,
   output logic         done
);

   localparam int NB = N / 8;
   localparam int IW = clog2_min1(NB);
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   p2s_state_t    state;
   logic [N-1:0]  result;
   logic [IW-1:0] idx;
   logic          first_wait;
   logic          tx_start_q;

   // Byte streaming FSM: latch the result, then request/await one byte at a time
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PS_IDLE;
         result     <= '0;
         idx        <= '0;
         first_wait <= 1'b0;
         tx_start_q <= 1'b0;
         tx_byte    <= 8'h00;
      end else begin
         tx_start_q <= 1'b0;
         case (state)
            PS_IDLE: begin
               if (load) begin
                  result <= result_in;
                  idx    <= LAST_IDX;
                  state  <= PS_SEND;
               end
            end
            PS_SEND: begin
               tx_start_q <= 1'b1;
               tx_byte    <= result[{idx, 3'b000} +: 8];
               first_wait <= 1'b1;
               state      <= PS_SEND_WAIT;
            end
            PS_SEND_WAIT: begin
               // The TX block only raises busy one cycle after the request, so skip that cycle
               if (first_wait) begin
                  first_wait <= 1'b0;
               end else if (!tx_busy) begin
                  if (idx == '0) begin
                     state <= PS_IDLE;
                  end else begin
                     idx   <= idx - 1'b1;
                     state <= PS_SEND;
                  end
               end
            end
            default: state <= PS_IDLE;
         endcase
      end
   end

   assign tx_start = tx_start_q & ~rst;
   assign done     = (state == PS_SEND_WAIT) && !first_wait && !tx_busy && (idx == '0);

endmodule

// File: rtl/rsa_uart_sequencer.sv
// Frame controller: sync byte, then msg/exp/mod words via serial_to_parallel, core run, result to UART TX.
// Latency: zero-cycle byte forwarding while loading; core_start one cycle after the mod word latches.
// Backpressure: none on RX (bytes outside a load phase are dropped); TX paced by tx_busy.
// Optional RSA_SEQ_TIMEOUT_EN: abandons a half-loaded frame after TIMEOUT_CYC idle cycles.
module rsa_uart_sequencer
   import rsa_uart_sequencer_pkg::*;
#(
   parameter int         N           = 32,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_valid,
   input  logic [7:0]   rx_byte,
   output logic         stp_rx_valid,
   output logic [7:0]   stp_rx_byte,
   output logic         stp_flush,
   input  logic         stp_valid,
   input  logic [N-1:0] stp_word,
   output logic [N-1:0] msg,
   output logic [N-1:0] exp,
   output logic [N-1:0] mod,
   output logic         core_start,
   input  logic         core_done,
   input  logic [N-1:0] core_result,
   output logic         tx_start,
   output logic [7:0]   tx_byte,
   input  logic         tx_busy,
   output logic         busy
);

   if ((N % 8) != 0 || N < 8 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("rsa_uart_sequencer: N must be a positive multiple of 8 and TIMEOUT_CYC at least 2");
   end

   seq_state_t state;
   logic       core_start_q;
   logic       flush_q;
   logic       loading;
   logic       timeout_hit;
   logic       p2s_load;
   logic       p2s_done;

   assign loading = (state == ST_LOAD_M) || (state == ST_LOAD_E) || (state == ST_LOAD_K);

`ifdef RSA_SEQ_TIMEOUT_EN
   localparam int TW = clog2_min1(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] idle_cnt;

   // Idle cycles since the last RX byte; only advances while an operand is being loaded
   always_ff @(posedge clk) begin
      if (rst || rx_valid || !loading) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign timeout_hit = loading && !rx_valid && (idle_cnt == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Frame sequencing FSM; operands only change when a new word is latched
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         msg          <= '0;
         exp          <= '0;
         mod          <= '0;
         core_start_q <= 1'b0;
         flush_q      <= 1'b1;
      end else begin
         core_start_q <= 1'b0;
         flush_q      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_valid && (rx_byte == SYNC_BYTE)) state <= ST_LOAD_M;
            end
            ST_LOAD_M: begin
               if (timeout_hit) begin
                  state   <= ST_IDLE;
                  flush_q <= 1'b1;
               end else if (stp_valid) begin
                  msg   <= stp_word;
                  state <= ST_LOAD_E;
               end
            end
            ST_LOAD_E: begin
               if (timeout_hit) begin
                  state   <= ST_IDLE;
                  flush_q <= 1'b1;
               end else if (stp_valid) begin
                  exp   <= stp_word;
                  state <= ST_LOAD_K;
               end
            end
            ST_LOAD_K: begin
               if (timeout_hit) begin
                  state   <= ST_IDLE;
                  flush_q <= 1'b1;
               end else if (stp_valid) begin
                  mod   <= stp_word;
                  state <= ST_START;
               end
            end
            ST_START: begin
               core_start_q <= 1'b1;
               state        <= ST_WAIT;
            end
            ST_WAIT: begin
               if (core_done) state <= ST_SEND;
            end
            ST_SEND: begin
               if (p2s_done) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign p2s_load     = (state == ST_WAIT) && core_done;
   assign stp_rx_valid = loading && rx_valid && !rst;
   assign stp_rx_byte  = rx_byte;
   assign stp_flush    = rst | flush_q;
   assign core_start   = core_start_q & ~rst;
   assign busy         = (state != ST_IDLE);

   rsa_uart_sequencer_p2s #(
      .N(N)
   ) u_p2s (
      .clk       (clk),
      .rst       (rst),
      .load      (p2s_load),
      .result_in (core_result),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_byte   (tx_byte),
      .done      (p2s_done)
   );

endmodule

// File: tb/tb_rsa_uart_sequencer.sv
// Bench for rsa_uart_sequencer: stub serial_to_parallel, stub core (msg^exp^mod after 5 cycles), stub UART TX.
// Expected operands and TX byte streams come from per-frame queues built from the bytes the bench sends.
module tb_rsa_uart_sequencer;

   localparam int N  = 32;
   localparam int NB = N / 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx_valid = 1'b0;
   logic [7:0]   rx_byte = 8'h00;
   logic         stp_rx_valid;
   logic [7:0]   stp_rx_byte;
   logic         stp_flush;
   logic         stp_valid = 1'b0;
   logic [N-1:0] stp_word = '0;
   logic [N-1:0] msg_o, exp_o, mod_o;
   logic         core_start;
   logic         core_done = 1'b0;
   logic [N-1:0] core_result = '0;
   logic         tx_start;
   logic [7:0]   tx_byte;
   logic         tx_busy;
   logic         busy;

   always #5 clk = ~clk;

   rsa_uart_sequencer #(
      .N(N), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .stp_rx_valid(stp_rx_valid), .stp_rx_byte(stp_rx_byte), .stp_flush(stp_flush),
      .stp_valid(stp_valid), .stp_word(stp_word),
      .msg(msg_o), .exp(exp_o), .mod(mod_o),
      .core_start(core_start), .core_done(core_done), .core_result(core_result),
      .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy), .busy(busy)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // ---------------- stub serial_to_parallel ----------------
   logic [23:0] s_acc = '0;
   int          s_cnt = 0;
   always @(posedge clk) begin
      stp_valid <= 1'b0;
      if (stp_flush) begin
         s_cnt <= 0;
         s_acc <= '0;
      end else if (stp_rx_valid) begin
         if (s_cnt == NB - 1) begin
            stp_valid <= 1'b1;
            stp_word  <= {s_acc, stp_rx_byte};
            s_cnt     <= 0;
         end else begin
            s_acc <= {s_acc[15:0], stp_rx_byte};
            s_cnt <= s_cnt + 1;
         end
      end
   end

   // ---------------- stub RSA core ----------------
   int           c_cnt = 0;
   logic [N-1:0] c_res = '0;
   always @(posedge clk) begin
      core_done <= 1'b0;
      if (rst) begin
         c_cnt <= 0;
      end else if (core_start) begin
         c_cnt <= 5;
         c_res <= msg_o ^ exp_o ^ mod_o;
      end else if (c_cnt != 0) begin
         c_cnt <= c_cnt - 1;
         if (c_cnt == 1) begin
            core_done   <= 1'b1;
            core_result <= c_res;
         end
      end
   end

   // ---------------- stub UART TX ----------------
   int busy_len = 3;
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (tx_start) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   // ---------------- model state ----------------
   logic             exp_fwd = 1'b0;
   logic [3*N-1:0]   exp_ops[$];
   logic [7:0]       exp_tx[$];
   logic [7:0]       tx_log[$];
   logic [3*N-1:0]   cmp_ops;
   int               tx_cnt = 0;
   int               start_cnt = 0;
   int               fwd_cnt = 0;
   logic [N-1:0]     last_msg = '0;

   // Per-cycle comparison against the frame-level model
   always @(negedge clk) begin
      if (rst) begin
         check("rst_stp_rx_valid", stp_rx_valid, 0);
         check("rst_core_start", core_start, 0);
         check("rst_tx_start", tx_start, 0);
         check("rst_stp_flush", stp_flush, 1);
      end else begin
         if (rx_valid || stp_rx_valid) begin
            check("stp_rx_valid", stp_rx_valid, rx_valid && exp_fwd);
            if (stp_rx_valid) begin
               fwd_cnt++;
               check("stp_rx_byte", stp_rx_byte, rx_byte);
            end
         end
         if (core_start) begin
            start_cnt++;
            if (exp_ops.size() == 0) begin
               check("unexpected_core_start", core_start, 0);
            end else begin
               cmp_ops = exp_ops.pop_front();
               check("start_msg", msg_o, cmp_ops[3*N-1:2*N]);
               check("start_exp", exp_o, cmp_ops[2*N-1:N]);
               check("start_mod", mod_o, cmp_ops[N-1:0]);
            end
         end
         if (tx_start) begin
            tx_cnt++;
            tx_log.push_back(tx_byte);
            check("tx_start_while_busy", tx_busy, 0);
            if (exp_tx.size() == 0) check("unexpected_tx_start", tx_start, 0);
            else check("tx_byte", tx_byte, exp_tx.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input logic fwd);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_byte = b; exp_fwd = fwd;
      @(posedge clk); #1;
      rx_valid = 1'b0; exp_fwd = 1'b0;
   endtask

   task automatic send_frame_bytes(input logic [N-1:0] m, input logic [N-1:0] e, input logic [N-1:0] k);
      logic [3*N-1:0] all;
      all = {m, e, k};
      send_byte(8'hA5, 1'b0);
      for (int i = 0; i < 3 * NB; i++) send_byte(all[3*N-1-8*i -: 8], 1'b1);
   endtask

   task automatic expect_frame(input logic [N-1:0] m, input logic [N-1:0] e, input logic [N-1:0] k);
      logic [N-1:0] r;
      r = m ^ e ^ k;
      exp_ops.push_back({m, e, k});
      for (int i = 0; i < NB; i++) exp_tx.push_back(r[N-1-8*i -: 8]);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, busy, 0);
   endtask

   task automatic run_frame(input string name, input logic [N-1:0] m, input logic [N-1:0] e,
                            input logic [N-1:0] k);
      int t0, s0;
      t0 = tx_cnt;
      s0 = start_cnt;
      expect_frame(m, e, k);
      send_frame_bytes(m, e, k);
      wait_idle({name, "_idle"}, 3000);
      check({name, "_tx_count"}, tx_cnt - t0, NB);
      check({name, "_start_count"}, start_cnt - s0, 1);
      check({name, "_tx_queue_left"}, exp_tx.size(), 0);
      last_msg = m;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; rx_valid = 1'b0; exp_fwd = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("flush_cycle_after_rst", stp_flush, 1);
      check("idle_after_rst", busy, 0);
      @(negedge clk);
      check("flush_released", stp_flush, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, f0, fl, k;
      logic seen;

      // Reset state
      do_reset();
      check("reset_msg", msg_o, 0);
      check("reset_exp", exp_o, 0);
      check("reset_mod", mod_o, 0);
      check("reset_tx_byte", tx_byte, 0);

      // 1: basic frame
      tx_log.delete();
      run_frame("t1", 32'h11223344, 32'h00000003, 32'h0000000D);
      check("t1_msg", msg_o, 32'h11223344);
      check("t1_exp", exp_o, 32'h00000003);
      check("t1_mod", mod_o, 32'h0000000D);
      check("t1_tx0", tx_log[0], 8'h11);
      check("t1_tx1", tx_log[1], 8'h22);
      check("t1_tx2", tx_log[2], 8'h33);
      check("t1_tx3", tx_log[3], 8'h4A);

      // 2: junk before sync is dropped, operands untouched until the next msg word
      f0 = fwd_cnt;
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      send_byte(8'h5A, 1'b0);
      check("t2_no_forward", fwd_cnt - f0, 0);
      check("t2_still_idle", busy, 0);
      check("t2_msg_stable", msg_o, 32'h11223344);
      run_frame("t2", 32'h11223344, 32'h00000003, 32'h0000000D);
      check("t2_msg", msg_o, 32'h11223344);

      // 3: sync byte value inside operand data
      run_frame("t3", 32'hCAFEBABE, 32'h00A50001, 32'h12345678);
      check("t3_exp", exp_o, 32'h00A50001);
      check("t3_msg", msg_o, 32'hCAFEBABE);

      // 4: slow TX
      busy_len = 20;
      tx_log.delete();
      run_frame("t4", 32'hDEADBEEF, 32'h00000001, 32'h0F0F0F0F);
      check("t4_tx0", tx_log[0], 8'hD1);
      check("t4_tx3", tx_log[3], 8'hE1);

      // 5a: reset during LOAD_E
      send_byte(8'hA5, 1'b0);
      send_byte(8'h99, 1'b1); send_byte(8'h88, 1'b1);
      send_byte(8'h77, 1'b1); send_byte(8'h66, 1'b1);
      send_byte(8'h55, 1'b1); send_byte(8'h44, 1'b1);
      check("t5a_loading", busy, 1);
      do_reset();
      run_frame("t5a", 32'h01020304, 32'h05060708, 32'h090A0B0C);
      check("t5a_msg", msg_o, 32'h01020304);

      // 5b: reset during SEND
      t0 = tx_cnt;
      expect_frame(32'h0BADF00D, 32'h00000010, 32'h00FF00FF);
      send_frame_bytes(32'h0BADF00D, 32'h00000010, 32'h00FF00FF);
      k = 0;
      while (tx_cnt == t0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("t5b_first_tx", tx_cnt - t0, 1);
      exp_tx.delete();
      do_reset();
      t0 = tx_cnt;
      repeat (60) @(negedge clk);
      check("t5b_no_tx_after_rst", tx_cnt - t0, 0);
      check("t5b_idle", busy, 0);
      busy_len = 3;
      run_frame("t5b", 32'hA5A5A5A5, 32'h00000002, 32'h0000FFFF);
      check("t5b_mod", mod_o, 32'h0000FFFF);

      // 6: stalled frame
      send_byte(8'hA5, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
`ifdef RSA_SEQ_TIMEOUT_EN
      seen = 1'b0;
      k = 0;
      while (busy && k < 80) begin
         @(negedge clk);
         if (stp_flush) seen = 1'b1;
         k++;
      end
      @(negedge clk);
      if (stp_flush) seen = 1'b1;
      check("t6_timeout_idle", busy, 0);
      check("t6_timeout_flush", seen, 1);
      check("t6_msg_kept", msg_o, last_msg);
`else
      fl = 0;
      repeat (100) begin
         @(negedge clk);
         if (stp_flush) fl++;
      end
      check("t6_no_flush", fl, 0);
      check("t6_stays_loading", busy, 1);
      do_reset();
`endif
      run_frame("t6", 32'h55667788, 32'h00000007, 32'h000000FF);
      check("t6_msg", msg_o, 32'h55667788);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
